pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 137 +++++++++++++
 tb/tb_pc_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter with an optional hardware return stack.
// The return stack (call/ret plus the stack flags) is built only when the
// macro PC_UNIT_STACK_EN is defined. Without it, call and ret are ignored,
// the stack flags are tied off and lower-priority commands still act.
module pc_unit #(
  parameter int AW = 8,
  parameter int SD = 4
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          en,
  input  logic          inc,
  input  logic          pc_in,
  input  logic          branch,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] data,
  input  logic [AW-1:0] offset,
  output logic [AW-1:0] pc_addr,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          stack_err
);

  logic [AW-1:0] pcAddr_q, pcAddr_d;
  logic          stackOwnsCmd;
  logic [AW-1:0] stackPc;

`ifdef PC_UNIT_STACK_EN
  localparam int PW = $clog2(SD + 1);

  logic [PW-1:0] stackPtr_q, stackPtr_d;
  logic          stackErr_q, stackErr_d;
  logic [AW-1:0] stack_q [SD];
  logic [AW-1:0] topEntry;
  logic [AW-1:0] pushVal;
  logic          pushEn;
  logic          stackFull, stackEmpty;

  assign stackFull   = (stackPtr_q == PW'(SD));
  assign stackEmpty  = (stackPtr_q == '0);
  assign pushVal     = pcAddr_q + AW'(1);
  assign stack_full  = stackFull;
  assign stack_empty = stackEmpty;
  assign stack_err   = stackErr_q;

  // Select the entry just below the pointer as the value a ret would pop.
  always_comb begin
    topEntry = '0;
    for (int i = 0; i < SD; i++) begin
      if (PW'(i) == stackPtr_q - PW'(1)) topEntry = stack_q[i];
    end
  end

  // Decide what a ret or call does this cycle; ret outranks call, and an
  // overflow or underflow only raises the sticky error.
  always_comb begin
    stackPtr_d   = stackPtr_q;
    stackErr_d   = stackErr_q;
    pushEn       = 1'b0;
    stackOwnsCmd = 1'b0;
    stackPc      = pcAddr_q;
    if (en) begin
      if (ret) begin
        stackOwnsCmd = 1'b1;
        if (stackEmpty) begin
          stackErr_d = 1'b1;
        end else begin
          stackPc    = topEntry;
          stackPtr_d = stackPtr_q - PW'(1);
        end
      end else if (call) begin
        stackOwnsCmd = 1'b1;
        if (stackFull) begin
          stackErr_d = 1'b1;
        end else begin
          pushEn     = 1'b1;
          stackPc    = data;
          stackPtr_d = stackPtr_q + PW'(1);
        end
      end
    end
  end

  // Stack storage carries no reset; a push coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    for (int i = 0; i < SD; i++) begin
      if (pushEn && !rst && PW'(i) == stackPtr_q) stack_q[i] <= pushVal;
    end
  end

  // Stack pointer and sticky error flag; only reset clears the error.
  always_ff @(posedge clock) begin
    if (rst) begin
      stackPtr_q <= '0;
      stackErr_q <= 1'b0;
    end else begin
      stackPtr_q <= stackPtr_d;
      stackErr_q <= stackErr_d;
    end
  end
`else
  logic unusedStack;

  assign unusedStack  = ^{call, ret};
  assign stackOwnsCmd = 1'b0;
  assign stackPc      = pcAddr_q;
  assign stack_full   = 1'b0;
  assign stack_empty  = 1'b1;
  assign stack_err    = 1'b0;
`endif

  // Next program address: stack commands first, then pc_in > branch > inc.
  always_comb begin
    pcAddr_d = pcAddr_q;
    if (en) begin
      if (stackOwnsCmd) begin
        pcAddr_d = stackPc;
      end else if (pc_in) begin
        pcAddr_d = data;
      end else if (branch) begin
        pcAddr_d = pcAddr_q + offset;
      end else if (inc) begin
        pcAddr_d = pcAddr_q + AW'(1);
      end
    end
  end

  // Program address register with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) pcAddr_q <= '0;
    else     pcAddr_q <= pcAddr_d;
  end

  assign pc_addr = pcAddr_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (AW=8, SD=4).
// Stack-specific vectors follow PC_UNIT_STACK_EN, matching the RTL build.
module tb_pc_unit;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_INC  = 5'b00001;
  localparam logic [4:0] C_BR   = 5'b00010;
  localparam logic [4:0] C_PIN  = 5'b00100;
  localparam logic [4:0] C_CALL = 5'b01000;
  localparam logic [4:0] C_RET  = 5'b10000;

  logic       clock = 1'b0;
  logic       rst, en, inc, pc_in, branch, call, ret;
  logic [7:0] data, offset;
  logic [7:0] pc_addr;
  logic       stack_full, stack_empty, stack_err;

  int checkCount = 0;
  int failCount  = 0;

  pc_unit #(.AW(8), .SD(4)) dut (
    .clock      (clock),
    .rst        (rst),
    .en         (en),
    .inc        (inc),
    .pc_in      (pc_in),
    .branch     (branch),
    .call       (call),
    .ret        (ret),
    .data       (data),
    .offset     (offset),
    .pc_addr    (pc_addr),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, let one rising edge pass, settle 1 time unit.
  task automatic applyStimulus(input logic r, input logic e, input logic [4:0] cmd,
                               input logic [7:0] d, input logic [7:0] off);
    rst    = r;
    en     = e;
    ret    = cmd[4];
    call   = cmd[3];
    pc_in  = cmd[2];
    branch = cmd[1];
    inc    = cmd[0];
    data   = d;
    offset = off;
    @(posedge clock);
    #1;
  endtask

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, C_NONE, 8'h00, 8'h00);

    // Reset wins over an enabled increment.
    applyStimulus(1'b1, 1'b1, C_INC, 8'h00, 8'h00);
    checkOutput("reset_pc", pc_addr, 8'h00);
    checkOutput("reset_empty", stack_empty, 1'b1);
    checkOutput("reset_full", stack_full, 1'b0);
    checkOutput("reset_err", stack_err, 1'b0);

    // Absolute load then increments across the wrap point, then hold.
    applyStimulus(1'b0, 1'b1, C_PIN, 8'hFE, 8'h00);
    checkOutput("load_fe", pc_addr, 8'hFE);
    applyStimulus(1'b0, 1'b1, C_INC, 8'h00, 8'h00);
    checkOutput("inc_ff", pc_addr, 8'hFF);
    applyStimulus(1'b0, 1'b1, C_INC, 8'h00, 8'h00);
    checkOutput("inc_wrap", pc_addr, 8'h00);
    applyStimulus(1'b0, 1'b1, C_INC, 8'h00, 8'h00);
    checkOutput("inc_01", pc_addr, 8'h01);
    applyStimulus(1'b0, 1'b0, C_INC, 8'h00, 8'h00);
    checkOutput("en_low_hold", pc_addr, 8'h01);

    // Relative branches: backwards by 16, then forwards by 5.
    applyStimulus(1'b0, 1'b1, C_PIN, 8'h10, 8'h00);
    applyStimulus(1'b0, 1'b1, C_BR, 8'h00, 8'hF0);
    checkOutput("branch_back", pc_addr, 8'h00);
    applyStimulus(1'b0, 1'b1, C_BR, 8'h00, 8'h05);
    checkOutput("branch_fwd", pc_addr, 8'h05);

    // Branch outranks inc; no command at all holds.
    applyStimulus(1'b0, 1'b1, C_BR | C_INC, 8'h00, 8'h03);
    checkOutput("branch_over_inc", pc_addr, 8'h08);
    applyStimulus(1'b0, 1'b1, C_NONE, 8'hAA, 8'h55);
    checkOutput("idle_hold", pc_addr, 8'h08);

`ifdef PC_UNIT_STACK_EN
    // Fill the stack with four calls, then overflow it.
    applyStimulus(1'b0, 1'b1, C_PIN, 8'h20, 8'h00);
    applyStimulus(1'b0, 1'b1, C_CALL, 8'h80, 8'h00);
    checkOutput("call1_pc", pc_addr, 8'h80);
    checkOutput("call1_empty", stack_empty, 1'b0);
    applyStimulus(1'b0, 1'b1, C_CALL, 8'h90, 8'h00);
    applyStimulus(1'b0, 1'b1, C_CALL, 8'hA0, 8'h00);
    checkOutput("call3_full", stack_full, 1'b0);
    applyStimulus(1'b0, 1'b1, C_CALL, 8'hB0, 8'h00);
    checkOutput("call4_pc", pc_addr, 8'hB0);
    checkOutput("call4_full", stack_full, 1'b1);
    checkOutput("call4_err", stack_err, 1'b0);
    applyStimulus(1'b0, 1'b1, C_CALL, 8'hC0, 8'h00);
    checkOutput("overflow_pc", pc_addr, 8'hB0);
    checkOutput("overflow_err", stack_err, 1'b1);
    checkOutput("overflow_full", stack_full, 1'b1);

    // Unwind: returns land one past each call site.
    applyStimulus(1'b0, 1'b1, C_RET, 8'h00, 8'h00);
    checkOutput("ret1_pc", pc_addr, 8'hA1);
    checkOutput("ret1_full", stack_full, 1'b0);
    applyStimulus(1'b0, 1'b1, C_RET, 8'h00, 8'h00);
    checkOutput("ret2_pc", pc_addr, 8'h91);
    applyStimulus(1'b0, 1'b0, C_RET, 8'h00, 8'h00);
    checkOutput("ret_en_low_hold", pc_addr, 8'h91);
    applyStimulus(1'b0, 1'b1, C_RET, 8'h00, 8'h00);
    checkOutput("ret3_pc", pc_addr, 8'h81);
    applyStimulus(1'b0, 1'b1, C_RET, 8'h00, 8'h00);
    checkOutput("ret4_pc", pc_addr, 8'h21);
    checkOutput("ret4_empty", stack_empty, 1'b1);
    checkOutput("err_sticky", stack_err, 1'b1);

    // Underflow on an empty stack; error survives later commands.
    applyStimulus(1'b1, 1'b0, C_NONE, 8'h00, 8'h00);
    checkOutput("rst_clears_err", stack_err, 1'b0);
    applyStimulus(1'b0, 1'b1, C_PIN, 8'h33, 8'h00);
    applyStimulus(1'b0, 1'b1, C_RET, 8'h00, 8'h00);
    checkOutput("underflow_pc", pc_addr, 8'h33);
    checkOutput("underflow_err", stack_err, 1'b1);
    applyStimulus(1'b0, 1'b1, C_INC, 8'h00, 8'h00);
    checkOutput("underflow_err_kept", stack_err, 1'b1);
    checkOutput("inc_after_err", pc_addr, 8'h34);

    // Priority: ret beats call, pc_in and inc with one entry of 0x44.
    applyStimulus(1'b1, 1'b0, C_NONE, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, C_PIN, 8'h43, 8'h00);
    applyStimulus(1'b0, 1'b1, C_CALL, 8'h99, 8'h00);
    checkOutput("prio_setup_pc", pc_addr, 8'h99);
    applyStimulus(1'b0, 1'b1, C_RET | C_CALL | C_PIN | C_INC, 8'h12, 8'h00);
    checkOutput("prio_ret_pc", pc_addr, 8'h44);
    checkOutput("prio_ret_empty", stack_empty, 1'b1);
    checkOutput("prio_ret_err", stack_err, 1'b0);

    // Call beats pc_in; reset in the same cycle as a call cancels it.
    applyStimulus(1'b0, 1'b1, C_CALL | C_PIN, 8'h60, 8'h00);
    checkOutput("call_over_pin", pc_addr, 8'h60);
    applyStimulus(1'b1, 1'b1, C_CALL, 8'h70, 8'h00);
    checkOutput("rst_call_pc", pc_addr, 8'h00);
    checkOutput("rst_call_empty", stack_empty, 1'b1);
`else
    // Without the stack, call and ret are invisible to priority.
    applyStimulus(1'b0, 1'b1, C_PIN, 8'h33, 8'h00);
    applyStimulus(1'b0, 1'b1, C_RET, 8'h00, 8'h00);
    checkOutput("nostack_ret_hold", pc_addr, 8'h33);
    checkOutput("nostack_ret_err", stack_err, 1'b0);
    applyStimulus(1'b0, 1'b1, C_RET | C_CALL | C_PIN | C_INC, 8'h12, 8'h00);
    checkOutput("nostack_prio_pc", pc_addr, 8'h12);
    checkOutput("nostack_prio_err", stack_err, 1'b0);
    checkOutput("nostack_empty", stack_empty, 1'b1);
    checkOutput("nostack_full", stack_full, 1'b0);
    applyStimulus(1'b0, 1'b1, C_CALL, 8'h77, 8'h00);
    checkOutput("nostack_call_hold", pc_addr, 8'h12);
    applyStimulus(1'b0, 1'b1, C_RET | C_CALL | C_BR, 8'h77, 8'h02);
    checkOutput("nostack_branch", pc_addr, 8'h14);
    applyStimulus(1'b0, 1'b1, C_RET | C_CALL | C_INC, 8'h77, 8'h00);
    checkOutput("nostack_inc", pc_addr, 8'h15);
    applyStimulus(1'b1, 1'b1, C_PIN, 8'h55, 8'h00);
    checkOutput("nostack_rst_pc", pc_addr, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
